alu_ser_responder: RTL and testbench

Serial-side front end of the ALU DUT and the responder end of the single-wire ALU protocol. It deserialises request frames on sin, assembles operands B and A plus the opcode, and checks the frame type sequence, CRC4 and opcode. Valid requests go to the ALU core over a valid/ready handshake. It then serialises either the data response (C plus flags, CRC3) or a single error control frame on sout.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_ser_frame_rx.sv | 56 +++++
 rtl/alu_ser_responder.sv | 207 ++++++++++++++++++++
 tb/tb_alu_ser_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/frame types, error bit positions, frame length and CRC helpers
// for the single-wire ALU responder.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_e;

    typedef enum logic {
        FT_DATA = 1'b0,
        FT_CTL  = 1'b1
    } frame_type_e;

    localparam int ERR_OP    = 0;
    localparam int ERR_CRC   = 1;
    localparam int ERR_DATA  = 2;
    localparam int NUM_ERR   = 3;
    localparam int FRAME_LEN = 11;

    // MSB-first LFSR, x^4+x+1, init 0.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
        end
        return c;
    endfunction

    // MSB-first LFSR, x^3+x+1, init 0.
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ ({3{fb}} & 3'b011);
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_ser_frame_rx.sv
// Frame deserialiser: detects a start bit while idle, shifts in type, byte and
// stop, then pulses done_o for one cycle with the captured fields.
module alu_ser_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       sin_i,
    output logic       start_o,
    output logic       done_o,
    output logic       type_o,
    output logic [7:0] byte_o,
    output logic       stop_ok_o
);

    logic       act_q;
    logic [3:0] cnt_q;
    logic [9:0] sh_q;
    logic       done_q;

    assign start_o   = en_i & ~act_q & ~sin_i;
    assign done_o    = done_q;
    assign type_o    = sh_q[9];
    assign byte_o    = sh_q[8:1];
    assign stop_ok_o = sh_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q  <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!en_i) begin
                act_q <= 1'b0;
                cnt_q <= '0;
            end else if (act_q) begin
                sh_q <= {sh_q[8:0], sin_i};
                // cnt_q counts the bits after the start bit; the last one is the stop bit
                if (cnt_q == 4'(FRAME_LEN - 2)) begin
                    act_q  <= 1'b0;
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (!sin_i) begin
                act_q <= 1'b1;
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_ser_responder.sv
// Responder end of the single-wire ALU protocol: collects a request packet,
// validates it, hands it to the core and serialises the data or error response.
module alu_ser_responder
    import alu_pkg::*;
#(
    parameter int RSP_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        sout,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_a,
    output logic [31:0] req_b,
    output logic [2:0]  req_op,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_c,
    input  logic [3:0]  rsp_flags,
    output logic        busy
);

    localparam int NUM_DATA = 8;
    localparam int GW       = (RSP_GAP > 0) ? $clog2(RSP_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_DISCARD, S_CHECK, S_REQ, S_WAIT_RSP, S_TX
    } state_e;

    state_e state_q, state_d;

    logic        rx_en, rx_start, rx_done, rx_type, rx_stop_ok;
    logic [7:0]  rx_byte;

    logic [63:0]        ba_q;
    logic [3:0]         cnt_q;
    logic [6:0]         ctl_q;
    logic [NUM_ERR-1:0] err_q;
    logic [31:0]        c_q;
    logic [3:0]         flags_q;
    logic               sout_q;
    logic [3:0]         tx_bit_q;
    logic [2:0]         tx_frm_q;
    logic [GW-1:0]      tx_gap_q;
    logic               tx_fin_q;

    logic        full, is_ctl, col_err, col_data, col_ctl;
    logic [2:0]  op;
    logic        crc_ok, op_ok;
    logic        tx_err;
    logic [5:0]  err_ef;
    logic        tx_type;
    logic [7:0]  tx_byte;
    logic [10:0] tx_frame;
    logic [3:0]  tx_bit_idx;
    logic [2:0]  tx_last;

    assign rx_en = (state_q == S_IDLE) || (state_q == S_COLLECT) || (state_q == S_DISCARD);

    alu_ser_frame_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .en_i      (rx_en),
        .sin_i     (sin),
        .start_o   (rx_start),
        .done_o    (rx_done),
        .type_o    (rx_type),
        .byte_o    (rx_byte),
        .stop_ok_o (rx_stop_ok)
    );

    assign full     = (cnt_q == 4'(NUM_DATA));
    assign is_ctl   = (rx_type == FT_CTL);
    assign col_data = rx_done & rx_stop_ok & ~is_ctl & ~full;
    assign col_ctl  = rx_done & rx_stop_ok & is_ctl & full;
    assign col_err  = rx_done & (~rx_stop_ok | (is_ctl & ~full) | (~is_ctl & full));

    assign op     = ctl_q[6:4];
    assign crc_ok = (crc4({ba_q, 1'b1, op}) == ctl_q[3:0]);
    assign op_ok  = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);

    assign req_valid = (state_q == S_REQ);
    assign req_b     = ba_q[63:32];
    assign req_a     = ba_q[31:0];
    assign req_op    = op;
    assign busy      = (state_q != S_IDLE);
    assign sout      = sout_q;

    // Error frame duplicates the flag triple; parity includes the leading 1.
    assign tx_err  = |err_q;
    assign err_ef  = {err_q[ERR_DATA], err_q[ERR_CRC], err_q[ERR_OP],
                      err_q[ERR_DATA], err_q[ERR_CRC], err_q[ERR_OP]};
    assign tx_last = tx_err ? 3'd0 : 3'd4;

    always_comb begin
        tx_type = FT_DATA;
        tx_byte = 8'h00;
        if (tx_err) begin
            tx_type = FT_CTL;
            tx_byte = {1'b1, err_ef, ^{1'b1, err_ef}};
        end else begin
            unique case (tx_frm_q)
                3'd0:    tx_byte = c_q[31:24];
                3'd1:    tx_byte = c_q[23:16];
                3'd2:    tx_byte = c_q[15:8];
                3'd3:    tx_byte = c_q[7:0];
                default: begin
                    tx_type = FT_CTL;
                    tx_byte = {1'b0, flags_q, crc3({c_q, 1'b0, flags_q})};
                end
            endcase
        end
    end

    assign tx_frame   = {1'b0, tx_type, tx_byte, 1'b1};
    assign tx_bit_idx = 4'(FRAME_LEN - 1) - tx_bit_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (rx_start) state_d = S_COLLECT;
            S_COLLECT: begin
                if (col_err)      state_d = S_DISCARD;
                else if (col_ctl) state_d = S_CHECK;
            end
            S_DISCARD:  if (rx_done && is_ctl) state_d = S_TX;
            S_CHECK:    state_d = (crc_ok && op_ok) ? S_REQ : S_TX;
            S_REQ:      if (req_ready) state_d = S_WAIT_RSP;
            S_WAIT_RSP: if (rsp_valid) state_d = S_TX;
            S_TX:       if (tx_fin_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ba_q     <= '0;
            cnt_q    <= '0;
            ctl_q    <= '0;
            err_q    <= '0;
            c_q      <= '0;
            flags_q  <= '0;
            sout_q   <= 1'b1;
            tx_bit_q <= '0;
            tx_frm_q <= '0;
            tx_gap_q <= '0;
            tx_fin_q <= 1'b0;
        end else begin
            if (state_q != S_TX) begin
                sout_q   <= 1'b1;
                tx_bit_q <= '0;
                tx_frm_q <= '0;
                tx_gap_q <= '0;
                tx_fin_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: if (rx_start) begin
                    err_q <= '0;
                    cnt_q <= '0;
                end
                S_COLLECT: begin
                    if (col_data) begin
                        ba_q  <= {ba_q[55:0], rx_byte};
                        cnt_q <= cnt_q + 4'd1;
                    end
                    if (col_ctl) ctl_q <= rx_byte[6:0];
                    if (col_err) err_q[ERR_DATA] <= 1'b1;
                end
                S_CHECK: begin
                    if (!crc_ok)     err_q[ERR_CRC] <= 1'b1;
                    else if (!op_ok) err_q[ERR_OP]  <= 1'b1;
                end
                S_WAIT_RSP: if (rsp_valid) begin
                    c_q     <= rsp_c;
                    flags_q <= rsp_flags;
                end
                S_TX: if (!tx_fin_q) begin
                    if (tx_gap_q != '0) begin
                        sout_q   <= 1'b1;
                        tx_gap_q <= tx_gap_q - GW'(1);
                    end else begin
                        sout_q <= tx_frame[tx_bit_idx];
                        if (tx_bit_q == 4'(FRAME_LEN - 1)) begin
                            tx_bit_q <= '0;
                            // tx_fin_q holds TX for the stop-bit cycle of the final frame
                            if (tx_frm_q == tx_last) begin
                                tx_fin_q <= 1'b1;
                            end else begin
                                tx_frm_q <= tx_frm_q + 3'd1;
                                tx_gap_q <= GW'(RSP_GAP);
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ser_responder.sv
// Randomised scoreboard bench for alu_ser_responder: stimulus pushes expected
// requests and response frames; independent monitors decode and compare.
module tb_alu_ser_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sin = 1'b1;
    logic        sout;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_op;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_c = '0;
    logic [3:0]  rsp_flags = '0;
    logic        busy;

    alu_ser_responder #(.RSP_GAP(0)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic typ; logic [7:0] byt; int need_rsp; } frm_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; } req_t;

    frm_t exp_frm[$];
    req_t exp_req[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   rsp_pulses = 0;
    int   ready_hold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC as the remainder of M(x)*x^deg divided by the generator polynomial.
    function automatic logic [3:0] ref_crc(input logic [127:0] msg, input int n,
                                           input logic [4:0] poly, input int deg);
        logic [127:0] r;
        logic [127:0] p;
        r = msg << deg;
        p = 128'(poly);
        for (int i = n + deg - 1; i >= deg; i--)
            if (r[i]) r = r ^ (p << (i - deg));
        return r[3:0];
    endfunction

    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] c;
        logic        cy, ov;
        c = '0; cy = 1'b0; ov = 1'b0; s = '0;
        case (op)
            3'b000: c = a & b;
            3'b001: c = a | b;
            3'b100: begin
                s = {1'b0, a} + {1'b0, b}; c = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                s = {1'b0, a} - {1'b0, b}; c = s[31:0]; cy = s[32];
                ov = (a[31] != b[31]) && (c[31] != a[31]);
            end
            default: c = '0;
        endcase
        return {cy, ov, (c == 32'd0), c[31], c};
    endfunction

    function automatic logic [7:0] err_byte(input logic d, input logic c, input logic o);
        logic [5:0] ef;
        ef = {d, c, o, d, c, o};
        return {1'b1, ef, ^{1'b1, ef}};
    endfunction

    function automatic frm_t mkf(input logic typ, input logic [7:0] byt, input int need);
        frm_t f;
        f.typ = typ; f.byt = byt; f.need_rsp = need;
        return f;
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] byt, input logic stop);
        logic [10:0] fb;
        fb = {1'b0, typ, byt, stop};
        for (int i = 10; i >= 0; i--) begin
            sin = fb[i];
            tick();
        end
        sin = 1'b1;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // mode: 0 good, 1 CRC over wrong marker bit, 2 early CTL, 3 bad stop, 4 extra DATA
    task automatic send_pkt(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] op, input int mode);
        logic [63:0] ba;
        logic [3:0]  crc;
        logic [35:0] r;
        logic [2:0]  c3;
        req_t        q;
        ba  = {b, a};
        crc = ref_crc(128'({b, a, (mode == 1) ? 1'b0 : 1'b1, op}), 68, 5'b10011, 4);
        for (int i = 0; i < 8; i++) begin
            if (mode == 2 && i == 3) send_frame(1'b1, 8'h5A, 1'b1);
            else send_frame(1'b0, ba[63 - 8*i -: 8], !(mode == 3 && i == 2));
        end
        if (mode == 4) send_frame(1'b0, 8'hA5, 1'b1);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);

        if (mode >= 2) exp_frm.push_back(mkf(1'b1, err_byte(1'b1, 1'b0, 1'b0), 0));
        else if (mode == 1) exp_frm.push_back(mkf(1'b1, err_byte(1'b0, 1'b1, 1'b0), 0));
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101}))
            exp_frm.push_back(mkf(1'b1, err_byte(1'b0, 1'b0, 1'b1), 0));
        else begin
            q.a = a; q.b = b; q.op = op;
            exp_req.push_back(q);
            valid_cnt++;
            r  = alu_ref(a, b, op);
            c3 = ref_crc(128'({r[31:0], 1'b0, r[35:32]}), 37, 5'b01011, 3)[2:0];
            for (int k = 0; k < 4; k++)
                exp_frm.push_back(mkf(1'b0, r[31 - 8*k -: 8], (k == 0) ? valid_cnt : 0));
            exp_frm.push_back(mkf(1'b1, {1'b0, r[35:32], c3}, 0));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_frm.size() != 0 || exp_req.size() != 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        chk("quiesce_in_time", 64'(n < 3000), 64'd1);
        repeat (3) tick();
    endtask

    // Core model: accepts after a delay, returns the result as a one-cycle pulse.
    initial begin
        logic [35:0] r;
        int          n;
        forever begin
            tick();
            if (!rst && req_valid && !req_ready) begin
                n = (ready_hold > 0) ? ready_hold : $urandom_range(0, 3);
                for (int i = 0; i < n; i++) begin
                    tick();
                    if (ready_hold > 0) chk("req_valid_held", 64'(req_valid), 64'd1);
                end
                r = alu_ref(req_a, req_b, req_op);
                req_ready = 1'b1;
                tick();
                req_ready = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
                rsp_c = r[31:0]; rsp_flags = r[35:32]; rsp_valid = 1'b1;
                rsp_pulses++;
                tick();
                rsp_valid = 1'b0;
                rsp_c = $urandom;
            end
        end
    end

    // Request monitor: operands must match the expectation every cycle req_valid is high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && req_valid) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got a=%h b=%h op=%b with nothing pending",
                             req_a, req_b, req_op);
                end else begin
                    chk("req_a", 64'(req_a), 64'(exp_req[0].a));
                    chk("req_b", 64'(req_b), 64'(exp_req[0].b));
                    chk("req_op", 64'(req_op), 64'(exp_req[0].op));
                    if (req_ready) void'(exp_req.pop_front());
                end
            end
        end
    end

    // Response monitor: decodes 11-bit frames from sout.
    initial begin
        logic [9:0] bits;
        frm_t       f;
        forever begin
            @(negedge clk);
            if (!rst && sout === 1'b0) begin
                for (int k = 9; k >= 0; k--) begin
                    @(negedge clk);
                    bits[k] = sout;
                end
                if (exp_frm.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got type=%b byte=%h with nothing pending",
                             bits[9], bits[8:1]);
                end else begin
                    f = exp_frm.pop_front();
                    chk("rsp_type", 64'(bits[9]), 64'(f.typ));
                    chk("rsp_byte", 64'(bits[8:1]), 64'(f.byt));
                    chk("rsp_stop", 64'(bits[0]), 64'd1);
                    if (f.need_rsp != 0)
                        chk("rsp_after_core", 64'(rsp_pulses >= f.need_rsp), 64'd1);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] fb;
        int          mode;
        logic [31:0] ra, rb;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_sout", 64'(sout), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req_valid", 64'(req_valid), 64'd0);
        chk("reset_req_a", 64'(req_a), 64'd0);
        chk("reset_req_b", 64'(req_b), 64'd0);
        chk("reset_req_op", 64'(req_op), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        send_pkt(32'd2, 32'd1, 3'b100, 0); wait_idle();
        send_pkt(32'd2, 32'd1, 3'b100, 1); wait_idle();
        send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 0); wait_idle();
        send_pkt(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b100, 2); wait_idle();
        send_pkt(32'h0000_0001, 32'h0000_0002, 3'b001, 3); wait_idle();
        send_pkt(32'h5555_AAAA, 32'h3333_CCCC, 3'b000, 4); wait_idle();

        ready_hold = 20;
        send_pkt(32'h0000_0005, 32'h0000_0003, 3'b101, 0); wait_idle();
        ready_hold = 0;

        // Asynchronous reset during bit 5 of the third frame.
        send_frame(1'b0, 8'hFF, 1'b1);
        send_frame(1'b0, 8'h00, 1'b1);
        fb = {1'b0, 1'b0, 8'hFF, 1'b1};
        for (int i = 10; i >= 5; i--) begin
            sin = fb[i];
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("midframe_rst_sout", 64'(sout), 64'd1);
        chk("midframe_rst_busy", 64'(busy), 64'd0);
        chk("midframe_rst_req_valid", 64'(req_valid), 64'd0);
        sin = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        send_pkt(32'hFF00_FF00, 32'hF0F0_F0F0, 3'b000, 0); wait_idle();

        for (int n = 0; n < 25; n++) begin
            mode = $urandom_range(0, 9);
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            if (mode <= 5) send_pkt(rb, ra, 3'($urandom_range(0, 7)), 0);
            else           send_pkt(rb, ra, 3'($urandom_range(0, 7)), mode - 5);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
